// File: rtl/pwm_pkg.sv
// Shared types and defaults for the phase-shifted PWM carrier logic.
package pwm_pkg;

    localparam int unsigned DefaultCounterWidth = 10;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } carrier_dir_e;

endpackage

// File: rtl/psc_pwm_generator_triangle_carrier.sv
// Up/down triangle counter 0..peak..0 with a single-cycle peak and valley.
module triangle_carrier
    import pwm_pkg::*;
#(
    parameter int unsigned CounterWidth = DefaultCounterWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    run_i,
    input  logic [CounterWidth-1:0] peak_i,
    output logic [CounterWidth-1:0] count_o,
    output carrier_dir_e            dir_o,
    output logic                    valley_o
);

    logic [CounterWidth-1:0] count_q, count_d;
    carrier_dir_e            dir_q, dir_d;

    // NOTE: next-state defaults are assigned first so no branch can infer a latch.
    always_comb begin
        count_d = count_q;
        dir_d   = dir_q;
        if (!run_i || peak_i == '0) begin
            count_d = '0;
            dir_d   = DIR_UP;
        end else begin
            count_d = (dir_q == DIR_UP) ? count_q + CounterWidth'(1)
                                        : count_q - CounterWidth'(1);
            // Turn around in the cycle the extreme is reached, so it is held only once.
            if (count_d == peak_i) begin
                dir_d = DIR_DOWN;
            end else if (count_d == '0) begin
                dir_d = DIR_UP;
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            dir_q   <= DIR_UP;
        end else begin
            count_q <= count_d;
            dir_q   <= dir_d;
        end
    end

    assign count_o  = count_q;
    assign dir_o    = dir_q;
    assign valley_o = (count_q == '0);

endmodule

// File: rtl/psc_pwm_generator.sv
// Two-cell phase-shifted PWM for a 3-level flying-capacitor leg; carrier B = P - A.
// Define PSC_PWM_TRIP_EN to add the trip_i input and the tripped_o latch.
module psc_pwm_generator
    import pwm_pkg::*;
#(
    parameter int unsigned CounterWidth = DefaultCounterWidth
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic [CounterWidth-1:0] period_i,
    input  logic [CounterWidth-1:0] duty_a_i,
    input  logic [CounterWidth-1:0] duty_b_i,
`ifdef PSC_PWM_TRIP_EN
    input  logic                    trip_i,
    output logic                    tripped_o,
`endif
    output logic                    s1_o,
    output logic                    s1n_o,
    output logic                    s2_o,
    output logic                    s2n_o,
    output logic                    sync_o
);

    logic [CounterWidth-1:0] period_q, period_d;
    logic [CounterWidth-1:0] duty_a_q, duty_a_d;
    logic [CounterWidth-1:0] duty_b_q, duty_b_d;
    logic [CounterWidth-1:0] carrier_a, carrier_b;
    carrier_dir_e            carrier_dir;
    logic                    carrier_valley;
    logic                    shadow_load, running, gate_off, raw_a, raw_b;
    logic                    s1_q, s1_d, s1n_q, s1n_d;
    logic                    s2_q, s2_d, s2n_q, s2n_d;
    logic                    sync_q, sync_d;
`ifdef PSC_PWM_TRIP_EN
    logic                    tripped_q, tripped_d;
`endif

    function automatic logic compare_raw(input logic [CounterWidth-1:0] duty,
                                         input logic [CounterWidth-1:0] period,
                                         input logic [CounterWidth-1:0] carrier);
        if (duty == '0)     return 1'b0;
        if (duty >= period) return 1'b1;
        return duty > carrier;
    endfunction

    // The carrier steps out of the valley with the value being loaded, so a new
    // period shapes its own first ramp.
    triangle_carrier #(
        .CounterWidth(CounterWidth)
    ) u_carrier (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .run_i   (running),
        .peak_i  (period_d),
        .count_o (carrier_a),
        .dir_o   (carrier_dir),
        .valley_o(carrier_valley)
    );

    always_comb begin
        shadow_load = carrier_valley || !enable_i;
        period_d    = shadow_load ? period_i : period_q;
        duty_a_d    = shadow_load ? duty_a_i : duty_a_q;
        duty_b_d    = shadow_load ? duty_b_i : duty_b_q;

        running   = enable_i && (period_q != '0);
        carrier_b = period_q - carrier_a;
        raw_a     = compare_raw(duty_a_q, period_q, carrier_a);
        raw_b     = compare_raw(duty_b_q, period_q, carrier_b);

`ifdef PSC_PWM_TRIP_EN
        // Trip wins over the clear condition; clearing needs enable low and trip gone.
        tripped_d = trip_i ? 1'b1 : (enable_i ? tripped_q : 1'b0);
        gate_off  = !running || trip_i || tripped_q;
`else
        gate_off  = !running;
`endif

        // Both legs come from one raw bit, so a pair is complementary or both off.
        s1_d   = !gate_off && raw_a;
        s1n_d  = !gate_off && !raw_a;
        s2_d   = !gate_off && raw_b;
        s2n_d  = !gate_off && !raw_b;
        sync_d = running && carrier_valley;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_q <= '0;
            duty_a_q <= '0;
            duty_b_q <= '0;
            s1_q     <= 1'b0;
            s1n_q    <= 1'b0;
            s2_q     <= 1'b0;
            s2n_q    <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            period_q <= period_d;
            duty_a_q <= duty_a_d;
            duty_b_q <= duty_b_d;
            s1_q     <= s1_d;
            s1n_q    <= s1n_d;
            s2_q     <= s2_d;
            s2n_q    <= s2n_d;
            sync_q   <= sync_d;
        end
    end

`ifdef PSC_PWM_TRIP_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tripped_q <= 1'b0;
        end else begin
            tripped_q <= tripped_d;
        end
    end

    assign tripped_o = tripped_q;
`endif

    assign s1_o   = s1_q;
    assign s1n_o  = s1n_q;
    assign s2_o   = s2_q;
    assign s2n_o  = s2n_q;
    assign sync_o = sync_q;

    carrier_dir_valid: assert property (@(posedge clk_i) disable iff (rst_i)
        (carrier_dir == DIR_DOWN) |-> (carrier_a != '0));

    gates_exclusive: assert property (@(posedge clk_i)
        !(s1_q && s1n_q) && !(s2_q && s2n_q));

endmodule

// File: tb/tb_psc_pwm_generator.sv
// Directed bench for psc_pwm_generator; trip scenario runs when PSC_PWM_TRIP_EN is defined.
module tb_psc_pwm_generator;

    localparam int W = 10;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         enable_i;
    logic [W-1:0] period_i, duty_a_i, duty_b_i;
    logic         s1_o, s1n_o, s2_o, s2n_o, sync_o;
`ifdef PSC_PWM_TRIP_EN
    logic         trip_i;
    logic         tripped_o;
`endif
    logic [4:0]   obs;

    int n_checks = 0;
    int n_pass   = 0;

    psc_pwm_generator #(
        .CounterWidth(W)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .period_i (period_i),
        .duty_a_i (duty_a_i),
        .duty_b_i (duty_b_i),
`ifdef PSC_PWM_TRIP_EN
        .trip_i   (trip_i),
        .tripped_o(tripped_o),
`endif
        .s1_o     (s1_o),
        .s1n_o    (s1n_o),
        .s2_o     (s2_o),
        .s2n_o    (s2n_o),
        .sync_o   (sync_o)
    );

    always #5 clk_i = ~clk_i;

    assign obs = {s1_o, s1n_o, s2_o, s2n_o, sync_o};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Carrier A value in cycle k of a run whose valley cycle is k = 0.
    function automatic int carrier_at(int k, int p);
        int m;
        if (p == 0) return 0;
        m = k % (2 * p);
        return (m <= p) ? m : 2 * p - m;
    endfunction

    function automatic logic raw_bit(int d, int p, int c);
        if (d == 0) return 1'b0;
        if (d >= p) return 1'b1;
        return d > c;
    endfunction

    // {s1, s1n, s2, s2n, sync} seen in cycle k: registered from cycle k-1.
    function automatic logic [4:0] exp_vec(int k, int p, int da, int db);
        int   a;
        logic ra, rb;
        if (p == 0) return 5'b0;
        a  = carrier_at(k - 1, p);
        ra = raw_bit(da, p, a);
        rb = raw_bit(db, p, p - a);
        return {ra, ~ra, rb, ~rb, a == 0};
    endfunction

    // Stop, load new settings while stopped, and re-enable; returns inside cycle 0.
    task automatic restart(input int p, input int da, input int db);
        @(negedge clk_i);
        enable_i = 1'b0;
        period_i = W'(p);
        duty_a_i = W'(da);
        duty_b_i = W'(db);
        @(negedge clk_i);
        check("disabled_1", obs, 5'b0);
        @(negedge clk_i);
        check("disabled_2", obs, 5'b0);
        enable_i = 1'b1;
    endtask

    task automatic run(input string tag, input int n, input int p, input int da, input int db);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk_i);
            check(tag, obs, exp_vec(k, p, da, db));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a, d, cnt_s1, cnt_s2;
        logic [4:0] e;

        rst_i    = 1'b1;
        enable_i = 1'b0;
        period_i = W'(10);
        duty_a_i = W'(5);
        duty_b_i = W'(5);
`ifdef PSC_PWM_TRIP_EN
        trip_i   = 1'b0;
`endif
        repeat (3) begin
            @(negedge clk_i);
            check("reset", obs, 5'b0);
        end
        rst_i = 1'b0;

        // P=10, D=5: 9-of-20 pulses; duty change 5->8 at A=4 rising applies after next valley.
        restart(10, 5, 5);
        cnt_s1 = 0;
        cnt_s2 = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk_i);
            a = carrier_at(k - 1, 10);
            d = (k - 1 >= 41) ? 8 : 5;
            e = {raw_bit(d, 10, a), ~raw_bit(d, 10, a),
                 raw_bit(5, 10, 10 - a), ~raw_bit(5, 10, 10 - a), a == 0};
            check("run", obs, e);
            if (k <= 20) begin
                cnt_s1 += int'(s1_o);
                cnt_s2 += int'(s2_o);
            end
            if (k == 24) duty_a_i = W'(8);
        end
        check("s1_high_count", cnt_s1, 9);
        check("s2_high_count", cnt_s2, 9);

        restart(10, 0, 5);
        run("duty_zero", 22, 10, 0, 5);
        restart(10, 10, 5);
        run("duty_eq_p", 22, 10, 10, 5);
        restart(10, 15, 0);
        run("duty_gt_p", 22, 10, 15, 0);
        restart(0, 5, 5);
        run("p_zero", 10, 0, 5, 5);
        restart(3, 2, 1);
        run("p_three", 14, 3, 2, 1);

        // Reset at A=7 with gates active; cleared shadow P holds one idle cycle.
        restart(10, 5, 5);
        run("pre_reset", 7, 10, 5, 5);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("reset_mid", obs, 5'b0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("reset_release", obs, 5'b0);
        run("after_reset", 22, 10, 5, 5);

`ifdef PSC_PWM_TRIP_EN
        restart(10, 5, 5);
        run("pre_trip", 3, 10, 5, 5);
        trip_i = 1'b1;
        @(negedge clk_i);
        trip_i = 1'b0;
        check("trip_gates", obs & 5'b11110, 5'b0);
        check("trip_latched", tripped_o, 1'b1);
        repeat (3) begin
            @(negedge clk_i);
            check("trip_hold_gates", obs & 5'b11110, 5'b0);
            check("trip_hold_flag", tripped_o, 1'b1);
        end
        enable_i = 1'b0;
        @(negedge clk_i);
        check("trip_cleared", tripped_o, 1'b0);
        restart(10, 5, 5);
        run("post_trip", 22, 10, 5, 5);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/psc_pwm_generator.md
PSC_PWM_GENERATOR -- requirements
Module: psc_pwm_generator

Interface
REQ-001 SHALL have parameter CounterWidth, default 10, carrier counter and compare width in bits.
REQ-002 SHALL have port clk_i  input  1  main clock.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port enable_i  input  1  run/stop; low stops modulation and holds all gate outputs low.
REQ-005 SHALL have port period_i  input  CounterWidth  carrier peak P; carrier period is 2P cycles.
REQ-006 SHALL have ports duty_a_i and duty_b_i  input  CounterWidth  compare values D_a, D_b for cell 1 and cell 2.
REQ-007 SHALL have ports s1_o, s1n_o, s2_o, s2n_o  output  1 each  complementary gate commands; each drives one dead_time_generator instance.
REQ-008 SHALL have port sync_o  output  1  one-cycle pulse at carrier A valley.

Function
REQ-009 SHALL run triangle carrier A: 0,1,...,P,P-1,...,1,0,1,... with one step per enabled clock.
REQ-010 SHALL derive carrier B = P - A, giving a 180-degree phase shift for 3LFCC natural balancing.
REQ-011 SHALL hold shadow copies of period_i, duty_a_i and duty_b_i. These SHALL load in every cycle where A==0 or enable_i is low. New values SHALL take effect the following cycle; mid-period input changes SHALL be ignored.
REQ-012 SHALL compute raw_x as follows: 0 if D_x==0; 1 if D_x>=P; otherwise (D_x > carrier_x). x=a uses A; x=b uses B.
REQ-013 SHALL register the outputs with one cycle latency: s1_o=raw_a and s1n_o=~raw_a; s2_o=raw_b and s2n_o=~raw_b.
REQ-014 SHALL ensure s1_o and s1n_o are never both 1, and likewise s2_o and s2n_o, in any cycle. This includes mode transitions.
REQ-015 SHALL, while enable_i is low: hold A=0 with direction up, drive all four gate outputs 0, and keep sync_o at 0.
REQ-016 SHALL start counting from A=0 with fresh shadow values in the first cycle after enable_i rises.
REQ-017 SHALL, when shadow P==0: hold A=0, drive all gate outputs 0, and keep sync_o at 0, even with enable_i high.
REQ-018 SHALL assert sync_o for exactly one cycle, in the cycle after A==0 while running. This cycle is aligned with the shadow load.
REQ-019 SHALL turn direction down in the cycle A reaches P, and up in the cycle A reaches 0. The peak and the valley SHALL each last exactly one cycle.

Reset
REQ-020 SHALL, on rst_i, set A=0, set direction up, clear all shadow registers, and drive s1_o, s1n_o, s2_o, s2n_o and sync_o to 0.
REQ-021 SHALL give rst_i priority over enable_i and over any trip input. Reset mid-period SHALL abort the period with no output glitch.

Configuration
REQ-022 SHALL, with macro PSC_PWM_TRIP_EN defined, add the following ports:
- trip_i  input  1
- tripped_o  output  1
REQ-023 SHALL, in that build, act on trip_i==1 as follows: all gate outputs go 0 on the next edge; tripped_o latches 1; outputs stay 0 until enable_i is low for at least one cycle and trip_i is 0.
REQ-024 SHALL, without PSC_PWM_TRIP_EN, omit trip_i, tripped_o and the latch, with otherwise identical behaviour.

Structure
REQ-025 SHALL take carrier direction typedef (DIR_UP/DIR_DOWN) and default CounterWidth constant from shared package pwm_pkg.
REQ-026 SHALL implement carrier A counting and direction in sub-module triangle_carrier. The outputs are count, direction and a valley flag.

Verification
REQ-027 SHALL verify: P=10, D_a=5, enable held -> s1_o high 9 of every 20 cycles, centred on A valley; s1n_o is its exact complement.
REQ-028 SHALL verify: P=10, D_a=D_b=5 -> s2_o pulses are centred on A peak (B valley), offset 10 cycles from s1_o.
REQ-029 SHALL verify: D_a changes 5->8 at A=4 rising -> the old duty is kept until the next A==0, and the new duty applies from the following cycle; sync_o pulses in that cycle.
REQ-030 SHALL verify: D_a=0 -> s1_o stays 0; D_a=10 or 15 with P=10 -> s1_o stays 1; P=0 -> all gate outputs stay 0.
REQ-031 SHALL verify: rst_i asserted at A=7 with outputs active -> next cycle all outputs 0 and A=0; after release, counting restarts from 0.
REQ-032 SHALL verify, with PSC_PWM_TRIP_EN: trip_i pulse for 1 cycle -> outputs 0 next edge and tripped_o=1; the latch holds until enable_i is low for one cycle.
